layer_mac_sequencer: RTL and testbench

//  Time-multiplexed controller for one fully-connected layer. A single shared 8x8 signed MAC

---
 rtl/layer_mac_sequencer.sv | 122 ++++++++++++
 tb/tb_layer_mac_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer
//   Evaluates one fully-connected layer by running every neuron through a
//   single shared 8x8 signed MAC. For each neuron n it streams activation and
//   weight reads for i = 0..N_IN-1, accumulates bias + sum(act*w) and
//   requantises the result (ReLU, round-half-up, saturate) to 0..127.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               request a layer evaluation (ignored while busy)
//   busy, done          busy through the run; done pulses once at the end
//   act_addr/act_data   activation buffer, 1-cycle synchronous read
//   w_addr/w_data       weight ROM (address n*N_IN+i), 1-cycle synchronous read
//   b_addr/b_data       bias ROM (address n), 1-cycle synchronous read
//   out_valid           one-cycle strobe qualifying out_idx/out_data
//   out_idx, out_data   neuron index and its requantised activation (held)
module layer_mac_sequencer #(
  parameter  int N_IN  = 15,
  parameter  int N_OUT = 16,
  parameter  int ACC_W = 23,
  parameter  int FRAC  = 6,
  localparam int AAW   = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int WAW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int BAW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [AAW-1:0] act_addr,
  input  logic [7:0]     act_data,
  output logic [WAW-1:0] w_addr,
  input  logic [7:0]     w_data,
  output logic [BAW-1:0] b_addr,
  input  logic [15:0]    b_data,
  output logic           out_valid,
  output logic [BAW-1:0] out_idx,
  output logic [7:0]     out_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EMIT, FIN} state_t;

  state_t state, state_nxt;

  logic [AAW-1:0]           i;
  logic [BAW-1:0]           n;
  logic                     rd_vld;    // read data for a previous ISSUE cycle is on the bus
  logic                     rd_first;  // that data is element 0: seed acc with the bias
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic signed [15:0]       a16, w16, prod;
  logic [7:0]               q_nxt;

  localparam logic [AAW-1:0] I_LAST = AAW'(N_IN - 1);
  localparam logic [BAW-1:0] N_LAST = BAW'(N_OUT - 1);

  function automatic logic [7:0] quant(input logic signed [ACC_W-1:0] a);
    logic [7:0] r;
    if (a[ACC_W-1]) return 8'd0;
    if (|a[ACC_W-2:FRAC+7]) return 8'd127;
    r = {1'b0, a[FRAC+6:FRAC]} + {7'd0, a[FRAC-1]};
    return r[7] ? 8'd127 : r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == FIN);
    out_valid = (state == EMIT);
    unique case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (i == I_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = EMIT;
      EMIT:    state_nxt = (n == N_LAST) ? FIN : ISSUE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign act_addr = i;
  assign b_addr   = n;
  assign w_addr   = WAW'(int'(n) * N_IN + int'(i));

  always_comb begin
    a16     = {8'd0, act_data};
    w16     = {{8{w_data[7]}}, w_data};
    prod    = a16 * w16;
    acc_nxt = (rd_first ? {{(ACC_W-16){b_data[15]}}, b_data} : acc)
              + {{(ACC_W-16){prod[15]}}, prod};
    q_nxt   = quant(acc_nxt);
  end

  // Products trail the addresses by one cycle, so the accumulate is driven by
  // a delayed copy of "ISSUE was active" rather than by the current state;
  // the DRAIN cycle therefore absorbs the final product automatically.
  always_ff @(posedge clk) begin
    if (reset) begin
      i        <= '0;
      n        <= '0;
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
      acc      <= '0;
      out_idx  <= '0;
      out_data <= '0;
    end else begin
      rd_vld   <= (state == ISSUE);
      rd_first <= (state == ISSUE) && (i == '0);
      if (state == ISSUE) i <= (i == I_LAST) ? '0 : i + 1'b1;
      if (state == EMIT)  n <= (n == N_LAST) ? '0 : n + 1'b1;
      if (rd_vld) acc <= acc_nxt;
      if (state == DRAIN) begin
        out_data <= q_nxt;
        out_idx  <= n;
      end
    end
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb_layer_mac_sequencer
//   Drives layer_mac_sequencer with directed and random ROM contents and
//   compares every result strobe, its timing, the read address stream and the
//   done pulse against a plain-arithmetic dot-product model.
module tb_layer_mac_sequencer;

  localparam int NI  = 15;
  localparam int NO  = 16;
  localparam int PER = NI + 2;
  localparam int RUN = NO * PER + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, out_valid;
  logic [3:0] act_addr, b_addr, out_idx;
  logic [7:0] w_addr;
  logic [7:0] act_data, w_data, out_data;
  logic [15:0] b_data;

  logic [7:0]         act_mem [16];
  logic signed [7:0]  w_mem   [256];
  logic signed [15:0] b_mem   [16];
  int                 exp_out [NO];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;
  int nv       = 0;
  int done_cnt = 0;
  bit armed    = 1'b0;

  layer_mac_sequencer #(.N_IN(NI), .N_OUT(NO), .ACC_W(23), .FRAC(6)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .act_addr(act_addr), .act_data(act_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .out_valid(out_valid), .out_idx(out_idx),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    act_data <= act_mem[act_addr];
    w_data   <= w_mem[w_addr];
    b_data   <= b_mem[b_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Cycle k counts from the cycle in which start was high (k=0).
  always @(negedge clk) begin
    int k, m, nn;
    if (done) done_cnt++;
    if (armed) begin
      k = cyc - t0;
      if (k >= 1 && k < RUN) begin
        m  = (k - 1) % PER;
        nn = (k - 1) / PER;
        if (m < NI)
          check("addr", int'({act_addr, w_addr, b_addr}),
                (m << 12) | ((nn * NI + m) << 4) | nn);
      end
      if (out_valid) begin
        if (nv < NO) begin
          check("valid_cycle", k, PER * (nv + 1));
          check("out_idx", int'(out_idx), nv);
          check("out_data", int'(out_data), exp_out[nv]);
        end else begin
          check("extra_valid", nv, NO - 1);
        end
        nv++;
      end
      if (done) check("done_cycle", k, RUN);
    end
  end

  task automatic calc_expected();
    for (int n = 0; n < NO; n++) begin
      int acc, r;
      acc = int'(b_mem[n]);
      for (int i = 0; i < NI; i++)
        acc += int'(act_mem[i]) * int'(w_mem[n * NI + i]);
      if (acc < 0) r = 0;
      else begin
        r = (acc + 32) / 64;
        if (r > 127) r = 127;
      end
      exp_out[n] = r;
    end
  endtask

  task automatic fill_const(input int a, input int w, input int b);
    for (int i = 0; i < 16; i++) act_mem[i] = 8'(a);
    for (int j = 0; j < 256; j++) w_mem[j] = 8'(w);
    for (int n = 0; n < 16; n++) b_mem[n] = 16'(b);
  endtask

  task automatic fill_random(input bit wide);
    for (int i = 0; i < 16; i++) act_mem[i] = 8'($urandom_range(0, 127));
    for (int j = 0; j < 256; j++)
      w_mem[j] = wide ? 8'($urandom) : 8'(int'($urandom_range(0, 16)) - 8);
    for (int n = 0; n < 16; n++)
      b_mem[n] = wide ? 16'($urandom) : 16'(int'($urandom_range(0, 8000)) - 2000);
  endtask

  // Entered #1 after a rising edge; leaves #1 after the edge that ends FIN,
  // so a following call starts in the first idle cycle.
  task automatic run_layer(input bit poke_start);
    int w;
    calc_expected();
    nv = 0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc - 1;
    armed = 1'b1;
    check("busy_on", int'(busy), 1);
    if (poke_start) begin
      repeat (40) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    w = 0;
    while (done_cnt == 0 && w < 2 * RUN) begin
      @(posedge clk); #1;
      w++;
    end
    check("done_count", done_cnt, 1);
    check("busy_off", int'(busy), 0);
    check("valid_count", nv, NO);
    armed = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_idx"}, int'(out_idx), 0);
    check({tag, "_addr"}, int'({act_addr, w_addr, b_addr}), 0);
  endtask

  initial begin
    int w;
    fill_const(0, 0, 0);
    // start held together with reset must be dropped
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b0;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    check("start_with_reset", int'(busy), 0);

    fill_const(64, 1, 0);          run_layer(1'b0);
    fill_const(127, 127, 0);       run_layer(1'b0);
    fill_const(127, -127, 0);      run_layer(1'b0);

    fill_const(0, 0, 0);
    b_mem[0] = 16'sd96;   b_mem[1] = 16'sd95;  b_mem[2] = 16'sd8160;
    b_mem[3] = -16'sd1;   b_mem[4] = 16'sd32;  b_mem[5] = 16'sd31;
    b_mem[6] = 16'sd8191; b_mem[7] = 16'sd8192; b_mem[8] = -16'sd32768;
    b_mem[9] = 16'sd32767; b_mem[10] = 16'sd8159;
    run_layer(1'b0);

    fill_random(1'b0);             run_layer(1'b1);

    // abort after the third result
    fill_random(1'b0);
    calc_expected();
    nv = 0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc - 1;
    armed = 1'b1;
    w = 0;
    while (nv < 3 && w < 4 * PER) begin
      @(negedge clk); #1;
      w++;
    end
    check("third_valid", nv, 3);
    armed = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle_outputs("abort");
    repeat (RUN + 20) @(posedge clk);
    #1 check("abort_no_done", done_cnt, 0);

    fill_random(1'b0);             run_layer(1'b0);
    fill_random(1'b1);             run_layer(1'b0);
    fill_random(1'b0);             run_layer(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
